top_0_spi: RTL and testbench

- Dual-channel SPI master transmitter with internal loopback receive, clocked from the APB-domain clock.
- Captures two 32-bit words at the start of each frame.
- Shifts the two words out MSB-first on two data lines that share one serial clock.
- Loops each line back internally, publishes the received words, and pulses an availability strobe.
- Free-running: frames repeat back-to-back, separated by a fixed idle gap.

---
 rtl/top_0_spi_pkg.sv | 26 ++
 rtl/spi_shift_channel.sv | 55 +++++
 rtl/top_0_spi.sv | 141 ++++++++++++++
 tb/tb_top_0_spi.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/top_0_spi_pkg.sv
// Shared definitions for the dual-channel SPI loopback transmitter.
// Holds the default geometry, the two-state sequencer encoding and the
// helper that sizes the shared gap/divider/bit counters.
package top_0_spi_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int CLK_DIV_DEF    = 4;
    localparam int GAP_CYCLES_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One width covers every counter: the largest terminal count decides it.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DATA_W_DEF, CLK_DIV_DEF, GAP_CYCLES_DEF);

endpackage

// File: rtl/spi_shift_channel.sv
// One SPI data lane: transmit shift register, registered serial output,
// loopback receive shift register and the published receive word.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - frame start: capture tx_word and drive its MSB
//   rise, fall  - SCLK rising / falling toggle strobes
//   done        - last falling toggle of the frame
//   tx_word     - word to transmit (sampled on load only)
//   sdo         - serial data out
//   rx_word     - last word received over the loopback path
module spi_shift_channel
    import top_0_spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              rise,
    input  logic              fall,
    input  logic              done,
    input  logic [DATA_W-1:0] tx_word,
    output logic              sdo,
    output logic [DATA_W-1:0] rx_word
);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            sdo     <= 1'b0;
            rx_word <= '0;
        end else if (load) begin
            tx_sr <= tx_word;
            sdo   <= tx_word[DATA_W-1];
        end else begin
            // Receiver samples the line it is driving (internal loopback).
            if (rise) begin
                rx_sr <= {rx_sr[DATA_W-2:0], sdo};
            end
            if (fall) begin
                tx_sr <= tx_sr << 1;
                // After the last bit the line returns to 0 for the gap.
                sdo   <= done ? 1'b0 : tx_sr[DATA_W-2];
            end
            if (done) begin
                rx_word <= rx_sr;
            end
        end
    end

endmodule

// File: rtl/top_0_spi.sv
// Free-running dual-channel SPI master (mode 0) with internal loopback.
// Every frame captures data_in_0/1, shifts both MSB-first on a shared SCLK,
// then publishes the looped-back words on data_0/1 with a SPIRXAVAIL pulse.
// Frames are separated by GAP_CYCLES idle PCLK cycles.
// Ports:
//   PCLK, PRESETN        - clock and asynchronous active-low reset
//   data_in_0/1          - transmit words, sampled at frame start
//   SPISDO_0/1           - serial data outputs
//   SPISCLKO             - shared serial clock, idles low
//   SPIMODE              - high for the whole frame
//   data_0/1             - last received words
//   SPIRXAVAIL           - one-cycle pulse when data_0/1 update
module top_0_spi
    import top_0_spi_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    output logic              SPISDO_0,
    output logic              SPISDO_1,
    output logic              SPISCLKO,
    output logic              SPIMODE,
    output logic [DATA_W-1:0] data_0,
    output logic [DATA_W-1:0] data_1,
    output logic              SPIRXAVAIL
);

    localparam int CNT_W = cnt_width(DATA_W, CLK_DIV, GAP_CYCLES);

    state_t           state, state_next;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             div_tc;
    logic             load, rise, fall, done;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        done       = 1'b0;
        div_tc     = (div_cnt == CNT_W'(CLK_DIV - 1));
        case (state)
            IDLE: begin
                if (gap_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tc) begin
                    // The current SCLK level tells which edge this toggle makes.
                    if (!SPISCLKO) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            done       = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            gap_cnt    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            SPISCLKO   <= 1'b0;
            SPIMODE    <= 1'b0;
            SPIRXAVAIL <= 1'b0;
        end else begin
            SPIRXAVAIL <= done;
            if (state == IDLE) begin
                if (load) begin
                    gap_cnt <= '0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    SPIMODE <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + CNT_W'(1);
                end
            end else begin
                if (div_tc) begin
                    div_cnt  <= '0;
                    SPISCLKO <= ~SPISCLKO;
                    if (fall) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (done) begin
                        SPISCLKO <= 1'b0;
                        SPIMODE  <= 1'b0;
                        gap_cnt  <= '0;
                    end
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end
        end
    end

    spi_shift_channel #(.DATA_W(DATA_W)) u_ch0 (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .load    (load),
        .rise    (rise),
        .fall    (fall),
        .done    (done),
        .tx_word (data_in_0),
        .sdo     (SPISDO_0),
        .rx_word (data_0)
    );

    spi_shift_channel #(.DATA_W(DATA_W)) u_ch1 (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .load    (load),
        .rise    (rise),
        .fall    (fall),
        .done    (done),
        .tx_word (data_in_1),
        .sdo     (SPISDO_1),
        .rx_word (data_1)
    );

endmodule

// File: tb/tb_top_0_spi.sv
// Self-checking bench for top_0_spi with a cycle-level reference model
// derived from frame/gap arithmetic.
module tb_top_0_spi;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int DATA_W     = 32;
    localparam int FRAME      = 2 * DATA_W * CLK_DIV;
    localparam int PERIOD     = FRAME + GAP_CYCLES;

    logic              PCLK;
    logic              PRESETN;
    logic [DATA_W-1:0] din0, din1;
    logic              SPISDO_0, SPISDO_1, SPISCLKO, SPIMODE, SPIRXAVAIL;
    logic [DATA_W-1:0] data_0, data_1;

    int checks   = 0;
    int failures = 0;

    // Model state
    int                c;           // negedges since reset release
    int                p;           // position in current frame period
    logic [DATA_W-1:0] cap0, cap1;  // words captured at frame start
    logic [DATA_W-1:0] exp_d0, exp_d1;

    top_0_spi #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .DATA_W(DATA_W)) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .data_in_0  (din0),
        .data_in_1  (din1),
        .SPISDO_0   (SPISDO_0),
        .SPISDO_1   (SPISDO_1),
        .SPISCLKO   (SPISCLKO),
        .SPIMODE    (SPIMODE),
        .data_0     (data_0),
        .data_1     (data_1),
        .SPIRXAVAIL (SPIRXAVAIL)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One PCLK cycle: advance the model, then compare every output.
    task automatic step();
        logic in_frame, rx_exp, sclk_exp, sdo0_exp, sdo1_exp;
        int   bi;
        @(negedge PCLK);
        c++;
        in_frame = 1'b0;
        rx_exp   = 1'b0;
        sclk_exp = 1'b0;
        sdo0_exp = 1'b0;
        sdo1_exp = 1'b0;
        if (c >= GAP_CYCLES) begin
            p        = (c - GAP_CYCLES) % PERIOD;
            in_frame = (p < FRAME);
        end else begin
            p = -1;
        end
        if (in_frame && p == 0) begin
            cap0 = din0;
            cap1 = din1;
        end
        if (p == FRAME) begin
            rx_exp = 1'b1;
            exp_d0 = cap0;
            exp_d1 = cap1;
        end
        if (in_frame) begin
            bi       = p / (2 * CLK_DIV);
            sclk_exp = ((p / CLK_DIV) % 2) == 1;
            sdo0_exp = cap0[DATA_W-1-bi];
            sdo1_exp = cap1[DATA_W-1-bi];
        end
        check_eq("spimode", {31'b0, SPIMODE},    {31'b0, in_frame});
        check_eq("sclk",    {31'b0, SPISCLKO},   {31'b0, sclk_exp});
        check_eq("sdo0",    {31'b0, SPISDO_0},   {31'b0, sdo0_exp});
        check_eq("sdo1",    {31'b0, SPISDO_1},   {31'b0, sdo1_exp});
        check_eq("rxavail", {31'b0, SPIRXAVAIL}, {31'b0, rx_exp});
        check_eq("data0",   data_0, exp_d0);
        check_eq("data1",   data_1, exp_d1);
    endtask

    task automatic wait_pos(input int target);
        bit found = 0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            step();
            if (p == target) found = 1;
        end
        if (!found) check_eq("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_reset();
        @(negedge PCLK);
        PRESETN = 1'b1;
        c       = 0;
        p       = -1;
        exp_d0  = '0;
        exp_d1  = '0;
        cap0    = '0;
        cap1    = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] s0, s1;
        PRESETN = 1'b0;
        din0    = '0;
        din1    = '0;
        repeat (10) @(negedge PCLK);
        check_eq("rst_sdo0",    {31'b0, SPISDO_0},   32'd0);
        check_eq("rst_sdo1",    {31'b0, SPISDO_1},   32'd0);
        check_eq("rst_sclk",    {31'b0, SPISCLKO},   32'd0);
        check_eq("rst_mode",    {31'b0, SPIMODE},    32'd0);
        check_eq("rst_rxavail", {31'b0, SPIRXAVAIL}, 32'd0);
        check_eq("rst_data0",   data_0, 32'd0);
        check_eq("rst_data1",   data_1, 32'd0);
        release_reset();

        // Zero data: two full frames
        wait_pos(FRAME);
        wait_pos(FRAME);
        check_eq("zero_d0", data_0, 32'd0);
        check_eq("zero_d1", data_1, 32'd0);

        // Loopback pattern, loaded during the gap
        din0 = 32'hAABB0134;
        din1 = 32'h12345678;
        wait_pos(FRAME);
        check_eq("loop_d0", data_0, 32'hAABB0134);
        check_eq("loop_d1", data_1, 32'h12345678);

        // Mid-frame change is ignored until the next frame
        wait_pos(100);
        din0 = 32'h43251672;
        wait_pos(FRAME);
        check_eq("mid_cur_d0", data_0, 32'hAABB0134);
        wait_pos(FRAME);
        check_eq("mid_next_d0", data_0, 32'h43251672);

        // Boundary patterns
        din0 = 32'h00000003;
        din1 = 32'hFFFFFFFF;
        wait_pos(FRAME);
        check_eq("bnd_d0", data_0, 32'h00000003);
        check_eq("bnd_d1", data_1, 32'hFFFFFFFF);

        // Random frames with random mid-frame disturbances
        for (int k = 0; k < 4; k++) begin
            s0   = $urandom;
            s1   = $urandom;
            din0 = s0;
            din1 = s1;
            wait_pos($urandom_range(1, FRAME - 1));
            din0 = $urandom;
            din1 = $urandom;
            wait_pos(FRAME);
            check_eq("rnd_d0", data_0, s0);
            check_eq("rnd_d1", data_1, s1);
        end

        // Reset mid-frame at bit 10 while SCLK is high
        din0 = 32'hFFFFFFFF;
        din1 = 32'hFFFFFFFF;
        wait_pos(10 * 2 * CLK_DIV + CLK_DIV + 1);
        #1;
        PRESETN = 1'b0;
        #1;
        check_eq("abort_sclk",    {31'b0, SPISCLKO},   32'd0);
        check_eq("abort_sdo0",    {31'b0, SPISDO_0},   32'd0);
        check_eq("abort_sdo1",    {31'b0, SPISDO_1},   32'd0);
        check_eq("abort_mode",    {31'b0, SPIMODE},    32'd0);
        check_eq("abort_rxavail", {31'b0, SPIRXAVAIL}, 32'd0);
        check_eq("abort_d0",      data_0, 32'd0);
        check_eq("abort_d1",      data_1, 32'd0);
        repeat (5) @(negedge PCLK);
        din0 = 32'h5A5AC3C3;
        din1 = 32'h0F0F8001;
        release_reset();
        wait_pos(FRAME);
        check_eq("restart_d0", data_0, 32'h5A5AC3C3);
        check_eq("restart_d1", data_1, 32'h0F0F8001);
        wait_pos(GAP_CYCLES - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
